// File: rtl/pcs_link_sequencer.sv
// Power-up, acquisition-retry and link-status sequencer driving the PCS receive Synchronization block.
// Latency: all outputs registered, valid in the cycle the state register holds the state; link_ok rises STABLE_CYCLES after first good sync.
// Backpressure: none; status is level-sampled every cycle. Optional macro PCS_LINK_SEQ_HOLDOFF_EN filters LINK_UP sync loss.
module pcs_link_sequencer #(
    parameter int RST_CYCLES     = 4,
    parameter int ACQ_TIMEOUT    = 64,
    parameter int STABLE_CYCLES  = 8,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 8,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             mr_main_reset_i,
    input  logic             power_good_i,
    input  logic             mr_restart_i,
    input  logic             code_sync_status_i,
    output logic             sync_power_on_o,
    output logic             sync_reset_o,
    output logic             link_ok_o,
    output logic             link_fault_o,
    output logic [1:0]       retry_count_o,
    output logic [CNT_W-1:0] sync_loss_count_o,
    output logic [2:0]       seq_state_o
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_POWER_UP  = 3'd1,
        ST_ACQUIRE   = 3'd2,
        ST_LINK_WAIT = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_RESTART   = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int TMR_MAX0 = (ACQ_TIMEOUT > RST_CYCLES) ? ACQ_TIMEOUT : RST_CYCLES;
    localparam int TMR_MAX1 = (TMR_MAX0 > STABLE_CYCLES) ? TMR_MAX0 : STABLE_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX1 > HOLDOFF_CYCLES) ? TMR_MAX1 : HOLDOFF_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST = TMR_W'(ACQ_TIMEOUT - 1);
    // The ACQUIRE exit sample is the first good sample, so LINK_WAIT needs one fewer.
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 2);
`ifdef PCS_LINK_SEQ_HOLDOFF_EN
    localparam logic [TMR_W-1:0] HLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);
`endif
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               tmr_clr;
    logic               pwr_q, srst_q, ok_q, fault_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        tmr_clr = 1'b0;
        if (!power_good_i) begin
            state_d = ST_OFF;
        end else if (mr_restart_i && (state_q != ST_OFF)) begin
            state_d = ST_RESTART;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                ST_OFF:      state_d = ST_POWER_UP;
                ST_POWER_UP,
                ST_RESTART: begin
                    if (timer_q >= RST_LAST) state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (code_sync_status_i) begin
                        state_d = ST_LINK_WAIT;
                    end else if (timer_q >= ACQ_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_RESTART;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_LINK_WAIT: begin
                    if (!code_sync_status_i) begin
                        state_d = ST_ACQUIRE;
                    end else if (timer_q >= STB_LAST) begin
                        state_d = ST_LINK_UP;
                        retry_d = 2'd0;
                    end
                end
                ST_LINK_UP: begin
`ifdef PCS_LINK_SEQ_HOLDOFF_EN
                    // Timer counts consecutive zero samples; any good sample restarts it.
                    if (code_sync_status_i) begin
                        tmr_clr = 1'b1;
                    end else if (timer_q >= HLD_LAST) begin
                        state_d = ST_ACQUIRE;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                    end
`else
                    if (!code_sync_status_i) begin
                        state_d = ST_ACQUIRE;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
                    end
`endif
                end
                ST_FAULT:    state_d = ST_FAULT;
                default:     state_d = ST_OFF;
            endcase
        end
        timer_d = ((state_d != state_q) || tmr_clr) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!mr_main_reset_i) begin
            state_q <= ST_OFF;
            timer_q <= '0;
            retry_q <= 2'd0;
            loss_q  <= '0;
            pwr_q   <= 1'b0;
            srst_q  <= 1'b1;
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            pwr_q   <= (state_d != ST_OFF);
            srst_q  <= (state_d == ST_OFF) || (state_d == ST_POWER_UP) ||
                       (state_d == ST_RESTART) || (state_d == ST_FAULT);
            ok_q    <= (state_d == ST_LINK_UP);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign sync_power_on_o   = pwr_q;
    assign sync_reset_o      = srst_q;
    assign link_ok_o         = ok_q;
    assign link_fault_o      = fault_q;
    assign retry_count_o     = retry_q;
    assign sync_loss_count_o = loss_q;
    assign seq_state_o       = state_q;

endmodule
